// File: rtl/rv32m_multiplier_pkg.sv
// Shared types for the RV32M multiplier: operation codes, FSM states and word types.
package rv32m_multiplier_pkg;

    typedef logic [31:0] rv32i_word;
    typedef logic [63:0] rv32i_double;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_ops_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } mul_state_t;

    // 0x80000000 maps to itself, which is correct once read as unsigned.
    function automatic rv32i_word magnitude(input rv32i_word v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/rv32m_multiplier_mul_product_reg.sv
// 64-bit product register: loads the multiplier, shifts right with the adder result, negates.
module mul_product_reg
    import rv32m_multiplier_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_init_i,
    input  logic        shift_add_i,
    input  logic        negate_i,
    input  logic [31:0] init_i,
    input  logic [31:0] sum_hi_i,
    input  logic        carry_i,
    output logic [63:0] product_o
);

    rv32i_double product_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            product_q <= '0;
        end else if (load_init_i) begin
            product_q <= {32'b0, init_i};
        end else if (shift_add_i) begin
            product_q <= {carry_i, sum_hi_i, product_q[31:1]};
        end else if (negate_i) begin
            product_q <= ~product_q + 64'd1;
        end
    end

    assign product_o = product_q;

endmodule

// File: rtl/rv32m_multiplier.sv
// Sequential shift-add multiplier for MUL/MULH/MULHSU/MULHU, fixed 34-cycle latency.
//   state | meaning
//   IDLE  | waiting for start; result held
//   SHIFT | one shift-add iteration per cycle, 32 total
//   FIXUP | apply sign correction to the 64-bit product
//   DONE  | result registered, done pulses for this cycle
module rv32m_multiplier
    import rv32m_multiplier_pkg::*;
#(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  mul_op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    mul_state_t  state_q;
    mul_ops_t    op_q;
    rv32i_word   mag_a_q;
    logic        neg_q;
    logic [CW-1:0] count_q;
    logic        done_q;
    rv32i_word   result_q;

    logic        a_signed, b_signed, neg_d, accept;
    rv32i_word   mag_a_d, mag_b_d, addend, sum_hi;
    logic        carry;
    rv32i_double product, fixed;

    always_comb begin
        a_signed = (mul_op_i == MULH) || (mul_op_i == MULHSU);
        b_signed = (mul_op_i == MULH);
        mag_a_d  = magnitude(a_i, a_signed);
        mag_b_d  = magnitude(b_i, b_signed);
        neg_d    = (a_signed & a_i[31]) ^ (b_signed & b_i[31]);
        accept   = (state_q == IDLE) && start_i && !kill_i;
        addend   = product[0] ? mag_a_q : 32'd0;
        {carry, sum_hi} = {1'b0, product[63:32]} + {1'b0, addend};
        fixed    = neg_q ? (~product + 64'd1) : product;
    end

    mul_product_reg u_product (
        .clk         (clk),
        .rst         (rst),
        .load_init_i (accept),
        .shift_add_i ((state_q == SHIFT) && !kill_i),
        .negate_i    ((state_q == FIXUP) && !kill_i && neg_q),
        .init_i      (mag_b_d),
        .sum_hi_i    (sum_hi),
        .carry_i     (carry),
        .product_o   (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= MUL;
            mag_a_q  <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= mul_ops_t'(mul_op_i);
                        mag_a_q <= mag_a_d;
                        neg_q   <= neg_d;
                        count_q <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (kill_i) begin
                        state_q <= IDLE;
                    end else begin
                        count_q <= count_q + CW'(1);
                        if (count_q == LAST) state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (kill_i) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= (op_q == MUL) ? fixed[31:0] : fixed[63:32];
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                // Already committed: kill cannot retract the done pulse here.
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_rv32m_multiplier.sv
// Directed and random checks of rv32m_multiplier with a result scoreboard.
module tb_rv32m_multiplier;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    rv32m_multiplier dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .mul_op_i (op),
        .a_i      (a),
        .b_i      (b),
        .kill_i   (kill),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex, ey, p;
        ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
        ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = ex * ey;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input bit push);
        op = o; a = x; b = y; start = 1'b1;
        if (push) sb.push_back(exp);
        tick;
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // Called in cycle T0+1; expects done in cycle T0+34. poke_at drives an ignored start.
    task automatic wait_done(input string tag, input int poke_at);
        int n = 1;
        bit seen = 1'b0;
        bit busy_gap = 1'b0;
        logic [31:0] exp;
        while (n <= 60 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_gap = 1'b1;
                if (n == poke_at) begin
                    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
                end
                tick;
                start = 1'b0;
                n++;
            end
        end
        check({tag, "_latency"}, n, 34);
        check({tag, "_busy_gap"}, {31'b0, busy_gap}, 32'd0);
        check({tag, "_busy_in_done"}, {31'b0, busy}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, "_result"}, result, exp);
        end
        tick;
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        check({tag, "_result_held"}, result, exp);
    endtask

    task automatic idle_no_done(input string tag, input int cycles);
        int dones = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done || busy) dones++;
            tick;
        end
        check(tag, dones, 0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
        tick; tick;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        tick;

        issue(2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b1);
        wait_done("mul_7x6", 0);
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1);
        wait_done("mul_m1m1", 0);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        wait_done("mulh_m1m1", 0);
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
        wait_done("mulhu_max", 0);
        issue(2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b1);
        wait_done("mulhsu_m1x2", 0);
        issue(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1);
        wait_done("mulh_min_min", 0);
        issue(2'b01, 32'h00000000, 32'h80000000, 32'h00000000, 1'b1);
        wait_done("mulh_zero", 0);

        // Start while busy is ignored; back-to-back start in the first idle cycle is accepted.
        issue(2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b1);
        wait_done("mul_ignored_start", 5);
        issue(2'b00, 32'd3, 32'd3, 32'd9, 1'b1);
        wait_done("mul_back_to_back", 0);

        // Kill mid-SHIFT at cycle T0+10.
        issue(2'b00, 32'd11, 32'd13, 32'd0, 1'b0);
        for (int i = 1; i < 10; i++) tick;
        kill = 1'b1;
        tick;
        kill = 1'b0;
        check("kill_busy", {31'b0, busy}, 32'd0);
        check("kill_done", {31'b0, done}, 32'd0);
        check("kill_result_kept", result, 32'd9);
        idle_no_done("kill_no_done", 40);
        issue(2'b00, 32'd5, 32'd5, 32'd25, 1'b1);
        wait_done("mul_after_kill", 0);

        // Reset mid-operation at cycle T0+20.
        issue(2'b11, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b0);
        for (int i = 1; i < 20; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);

        // kill wins over start in IDLE.
        op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1; kill = 1'b1;
        tick;
        start = 1'b0; kill = 1'b0;
        check("kill_start_busy", {31'b0, busy}, 32'd0);
        idle_no_done("kill_start_no_op", 40);
        check("kill_start_result", result, 32'd0);

        for (int k = 0; k < 6; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            issue(ro, ra, rb, model(ro, ra, rb), 1'b1);
            wait_done("random_op", 0);
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
